// File: rtl/stbus_pkg.sv
// Shared types and defaults for the ST-bus receive deserializer.
package stbus_pkg;

    localparam int unsigned NCH_DEF       = 4;
    localparam int unsigned WORD_BITS_DEF = 32;

    typedef enum logic [1:0] {
        DISARM,
        IDLE,
        SHIFT
    } lane_state_e;

    typedef struct packed {
        logic [WORD_BITS_DEF-1:0] data;
        logic                     is_short;
    } hold_t;

endpackage

// File: rtl/stbus_rx_lane.sv
// One ST-bus receive lane: input synchronizers, edge detect, burst FSM,
// shift register/bit count and a single-word hold register with overflow.
module stbus_rx_lane
    import stbus_pkg::*;
#(
    parameter int unsigned WORD_BITS = WORD_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 burst_clk,
    input  logic                 burst_en,
    input  logic                 sdata,
    input  logic                 take,
    output logic                 hold_full,
    output logic [WORD_BITS-1:0] hold_data,
    output logic                 hold_short,
    output logic                 ovf
);

    localparam int unsigned CW = $clog2(WORD_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORD_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WORD_BITS + 1);

    logic [2:0] clk_sync;
    logic [2:0] en_sync;
    logic [1:0] sd_sync;
    logic [1:0] settle;

    logic clk_rise;
    logic en_now;
    logic en_rise;
    logic en_fall;
    logic sd_bit;

    lane_state_e state;
    lane_state_e state_nx;

    logic do_clear;
    logic do_shift;
    logic do_close;

    logic [WORD_BITS-1:0] shreg;
    logic [WORD_BITS-1:0] shreg_nx;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '0;
            en_sync  <= '0;
            sd_sync  <= '0;
            settle   <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], burst_clk};
            en_sync  <= {en_sync[1:0], burst_en};
            sd_sync  <= {sd_sync[0], sdata};
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end
        end
    end

    assign clk_rise = clk_sync[1] & ~clk_sync[2];
    assign en_now   = en_sync[1];
    assign en_rise  = en_sync[1] & ~en_sync[2];
    assign en_fall  = ~en_sync[1] & en_sync[2];
    assign sd_bit   = sd_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DISARM;
        end else begin
            state <= state_nx;
        end
    end

    // DISARM waits for the zeroed synchronizers to refill, so an enable that
    // was already high at reset release is seen as high and not as a new burst.
    always_comb begin
        state_nx = state;
        unique case (state)
            DISARM:  if (settle == 2'd3 && !en_now) state_nx = IDLE;
            IDLE:    if (en_rise)                   state_nx = SHIFT;
            SHIFT:   if (en_fall)                   state_nx = IDLE;
            default:                                state_nx = DISARM;
        endcase
    end

    always_comb begin
        do_clear = 1'b0;
        do_shift = 1'b0;
        do_close = 1'b0;
        unique case (state)
            IDLE:  do_clear = en_rise;
            SHIFT: begin
                do_shift = clk_rise;
                do_close = en_fall;
            end
            default: ;
        endcase
    end

    // A bit arriving in the closing cycle is folded into the closed word.
    always_comb begin
        shreg_nx = shreg;
        cnt_nx   = cnt;
        if (do_shift) begin
            shreg_nx = {shreg[WORD_BITS-2:0], sd_bit};
            if (cnt != CNT_SAT) begin
                cnt_nx = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            hold_full  <= 1'b0;
            hold_data  <= '0;
            hold_short <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (do_clear) begin
                shreg <= '0;
                cnt   <= '0;
            end else begin
                shreg <= shreg_nx;
                cnt   <= cnt_nx;
            end

            if (take) begin
                hold_full <= 1'b0;
            end

            // The arbiter draining the hold this cycle frees it for the new word.
            if (do_close) begin
                if (!hold_full || take) begin
                    hold_data  <= shreg_nx;
                    hold_short <= (cnt_nx != CNT_FULL);
                    hold_full  <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stbus_rx_deser.sv
// ST-bus receive deserializer: NCH lanes merged round-robin onto one
// valid/ready word stream with a single output register.
module stbus_rx_deser
    import stbus_pkg::*;
#(
    parameter int unsigned NCH       = NCH_DEF,
    parameter int unsigned WORD_BITS = WORD_BITS_DEF,
    parameter int unsigned LW        = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       burst_clk,
    input  logic [NCH-1:0]       burst_en,
    input  logic [NCH-1:0]       sdata,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_BITS-1:0] m_data,
    output logic [LW-1:0]        m_lane,
    output logic                 m_short,
    output logic [NCH-1:0]       ovf
);

    logic [NCH-1:0]       hold_full;
    logic [WORD_BITS-1:0] hold_data [NCH];
    logic [NCH-1:0]       hold_short;
    logic [NCH-1:0]       take;

    logic [LW-1:0] rr_ptr;
    logic [LW-1:0] gnt_idx;
    logic          gnt_found;
    logic          out_load;
    int unsigned   idx;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        stbus_rx_lane #(
            .WORD_BITS(WORD_BITS)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .burst_clk  (burst_clk[g]),
            .burst_en   (burst_en[g]),
            .sdata      (sdata[g]),
            .take       (take[g]),
            .hold_full  (hold_full[g]),
            .hold_data  (hold_data[g]),
            .hold_short (hold_short[g]),
            .ovf        (ovf[g])
        );
    end

    assign out_load = !m_valid || m_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        take      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (32'(rr_ptr) + i) % NCH;
            if (!gnt_found && hold_full[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = LW'(idx);
            end
        end
        if (out_load && gnt_found) begin
            take[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_lane  <= '0;
            m_short <= 1'b0;
            rr_ptr  <= '0;
        end else if (out_load) begin
            if (gnt_found) begin
                m_valid <= 1'b1;
                m_data  <= hold_data[gnt_idx];
                m_lane  <= gnt_idx;
                m_short <= hold_short[gnt_idx];
                rr_ptr  <= (gnt_idx == LW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stbus_rx_deser.sv
// Scoreboard bench for stbus_rx_deser: directed bursts push expected words,
// a monitor pops and compares on every accepted output word.
module tb_stbus_rx_deser;

    localparam int unsigned NCH = 4;
    localparam int unsigned WB  = 32;

    logic          clk;
    logic          rst;
    logic [NCH-1:0] burst_clk;
    logic [NCH-1:0] burst_en;
    logic [NCH-1:0] sdata;
    logic          m_valid;
    logic          m_ready;
    logic [WB-1:0] m_data;
    logic [1:0]    m_lane;
    logic          m_short;
    logic [NCH-1:0] ovf;

    typedef struct packed {
        logic [WB-1:0] data;
        logic [1:0]    lane;
        logic          is_short;
    } exp_t;

    exp_t sbq[$];
    int   pop_cycs[$];
    exp_t e;
    int   cyc;
    int   checks;
    int   errors;
    int   n;

    stbus_rx_deser #(
        .NCH(NCH),
        .WORD_BITS(WB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .burst_clk (burst_clk),
        .burst_en  (burst_en),
        .sdata     (sdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_lane    (m_lane),
        .m_short   (m_short),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] l, input logic s);
        exp_t x;
        x.data     = d;
        x.lane     = l;
        x.is_short = s;
        sbq.push_back(x);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #2 m_ready = r;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Bits go out MSB first from bits[n-1]; sdata changes with burst_clk low.
    task automatic burst(input int lane, input logic [63:0] bits, input int nb, input bit coinc);
        burst_en[lane] = 1'b1;
        #40;
        for (int i = nb - 1; i >= 0; i--) begin
            sdata[lane]     = bits[i];
            burst_clk[lane] = 1'b0;
            #40;
            if (i == 0 && coinc) begin
                burst_clk[lane] = 1'b1;
                burst_en[lane]  = 1'b0;
                #40;
                burst_clk[lane] = 1'b0;
                #40;
            end else begin
                burst_clk[lane] = 1'b1;
                #40;
            end
        end
        if (!coinc) begin
            burst_clk[lane] = 1'b0;
            #40;
            burst_en[lane] = 1'b0;
        end
        #40;
    endtask

    task automatic stray(input int lane, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            sdata[lane]     = ~sdata[lane];
            burst_clk[lane] = 1'b1;
            #40;
            burst_clk[lane] = 1'b0;
            #40;
        end
    endtask

    task automatic drain(input string name, input int max);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d words outstanding required 0", name, sbq.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_data"},  64'(m_data),  64'd0);
        chk({tag, "_m_lane"},  64'(m_lane),  64'd0);
        chk({tag, "_m_short"}, 64'(m_short), 64'd0);
        chk({tag, "_ovf"},     64'(ovf),     64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        m_ready   = 1'b1;
        burst_clk = '0;
        burst_en  = '0;
        sdata     = '0;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst && m_valid && m_ready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got lane=%0d data=%h short=%0d required no word",
                                 m_lane, m_data, m_short);
                    end else begin
                        e = sbq.pop_front();
                        pop_cycs.push_back(cyc);
                        if (m_data !== e.data || m_lane !== e.lane || m_short !== e.is_short) begin
                            errors++;
                            $display("FAIL word: got lane=%0d data=%h short=%0d required lane=%0d data=%h short=%0d",
                                     m_lane, m_data, m_short, e.lane, e.data, e.is_short);
                        end
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: got timeout required completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check_reset_state("reset");
        repeat (10) @(negedge clk);

        // Full 32-bit word on lane 0, latency from enable fall.
        push(32'hA5C3_0F96, 2'd0, 1'b0);
        @(negedge clk);
        fork
            burst(0, 64'hA5C3_0F96, 32, 1'b0);
            begin
                wait (burst_en[0] == 1'b1);
                wait (burst_en[0] == 1'b0);
                n = 0;
                while (!m_valid && n < 8) begin
                    @(negedge clk);
                    n++;
                end
                chk("lat_valid", 64'(m_valid), 64'd1);
                chk("lat_le5", 64'(n <= 5), 64'd1);
            end
        join
        drain("lane0_word", 50);

        // All lanes close together; round-robin from lane 0, no bubbles.
        do_reset();
        check_reset_state("reset2");
        repeat (10) @(negedge clk);
        for (int l = 0; l < 4; l++) push(32'h1111_1111 * (l + 1), 2'(l), 1'b0);
        pop_cycs.delete();
        @(negedge clk);
        fork
            burst(0, 64'h1111_1111, 32, 1'b0);
            burst(1, 64'h2222_2222, 32, 1'b0);
            burst(2, 64'h3333_3333, 32, 1'b0);
            burst(3, 64'h4444_4444, 32, 1'b0);
        join
        drain("four_lanes", 50);
        chk("rr_count", 64'(pop_cycs.size()), 64'd4);
        for (int k = 1; k < 4; k++) begin
            if (pop_cycs.size() == 4) chk("rr_consecutive", 64'(pop_cycs[k] - pop_cycs[k-1]), 64'd1);
        end

        // Short and long bursts on lane 1.
        push(32'h7FFF_FFFF, 2'd1, 1'b1);
        @(negedge clk);
        burst(1, 64'h7FFF_FFFF, 31, 1'b0);
        drain("short31", 50);
        push(32'h1234_5678, 2'd1, 1'b1);
        @(negedge clk);
        burst(1, 64'h1_1234_5678, 33, 1'b0);
        drain("long33", 50);

        // Stall on lane 2: output reg and hold fill, third word overflows.
        set_ready(1'b0);
        push(32'hDEAD_BEEF, 2'd2, 1'b0);
        push(32'h1234_5678, 2'd2, 1'b0);
        @(negedge clk);
        burst(2, 64'hDEAD_BEEF, 32, 1'b0);
        repeat (8) @(negedge clk);
        chk("stall1_valid", 64'(m_valid), 64'd1);
        chk("stall1_data", 64'(m_data), 64'hDEAD_BEEF);
        burst(2, 64'h1234_5678, 32, 1'b0);
        repeat (8) @(negedge clk);
        chk("stall2_data", 64'(m_data), 64'hDEAD_BEEF);
        chk("stall2_ovf", 64'(ovf), 64'h0);
        burst(2, 64'hFFFF_0000, 32, 1'b0);
        repeat (8) @(negedge clk);
        chk("stall3_data", 64'(m_data), 64'hDEAD_BEEF);
        chk("stall3_lane", 64'(m_lane), 64'd2);
        chk("stall3_ovf", 64'(ovf), 64'h4);
        set_ready(1'b1);
        drain("stall_release", 50);
        chk("post_release_valid", 64'(m_valid), 64'd0);
        chk("ovf_sticky", 64'(ovf), 64'h4);

        // Reset mid-burst on lane 3 with enable still high at release.
        @(negedge clk);
        fork
            burst(3, 64'h000F_FFFF, 20, 1'b0);
            begin
                #(40 + 8 * 80);
                do_reset();
            end
        join
        chk("ovf_cleared", 64'(ovf), 64'h0);
        repeat (12) @(negedge clk);
        chk("no_partial_word", 64'(m_valid), 64'd0);
        push(32'hCAFE_F00D, 2'd3, 1'b0);
        @(negedge clk);
        burst(3, 64'hCAFE_F00D, 32, 1'b0);
        drain("after_reset_word", 50);

        // Stray edges with enable low, last edge coincident with enable fall.
        push(32'h0F0F_3C3C, 2'd0, 1'b0);
        @(negedge clk);
        stray(0, 3);
        burst(0, 64'h0F0F_3C3C, 32, 1'b1);
        stray(0, 3);
        drain("coincident", 50);
        repeat (10) @(negedge clk);
        chk("queue_empty", 64'(sbq.size()), 64'd0);
        chk("final_valid", 64'(m_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
